// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the shift-add multiplier.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of RUN steps needed to consume a w-bit multiplier d bits at a time.
   function automatic int num_digits(input int w, input int d);
      return w / d;
   endfunction

   function automatic int clog2(input int v);
      int res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << res) < 64'(v)) res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mul_digit_step.sv
// One digit-serial step: acc + (mcand * slice) << (cnt * digit).
module mul_digit_step #(
   parameter int width = 128,
   parameter int digit = 4,
   parameter int cnt_w = 6
) (
   input  logic [2*width-1:0] acc,
   input  logic [width-1:0]   mcand,
   input  logic [digit-1:0]   slice,
   input  logic [cnt_w-1:0]   cnt,
   output logic [2*width-1:0] next_acc
);

   logic [width+digit-1:0] pp;
   logic [2*width-1:0]     pp_ext;
   int unsigned            sh;

   always_comb begin
      pp       = (width+digit)'(mcand) * (width+digit)'(slice);
      pp_ext   = (2*width)'(pp);
      sh       = 32'(cnt) * 32'(digit);
      next_acc = acc + (pp_ext << sh);
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned multiplier: r = a*b in width/digit RUN cycles,
// enable/done/r producer handshake.
module shift_add_multiplier
   import mul_pkg::*;
#(
   parameter int width = 128,
   parameter int digit = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [width-1:0]   a,
   input  logic [width-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*width-1:0] r
);

   localparam int K  = num_digits(width, digit);
   localparam int CW = clog2(K) + 1;
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   if (width % digit != 0) begin : g_bad_digit
      $error("shift_add_multiplier: width must be a multiple of digit");
   end

   // Handshake: enable is sampled only in IDLE or DONE; done stays high with
   // r stable until the next accepted enable.
   state_t             state, next_state;
   logic [width-1:0]   mcand, mplier;
   logic [2*width-1:0] acc, step_acc;
   logic [CW-1:0]      cnt;
   logic               last_step;

   assign last_step = (cnt == LAST);

   mul_digit_step #(
      .width (width),
      .digit (digit),
      .cnt_w (CW)
   ) u_step (
      .acc      (acc),
      .mcand    (mcand),
      .slice    (mplier[digit-1:0]),
      .cnt      (cnt),
      .next_acc (step_acc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (enable)    next_state = RUN;
         RUN:     if (last_step) next_state = DONE;
         DONE:    if (enable)    next_state = RUN;
         default:                next_state = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         r      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (enable) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               acc    <= step_acc;
               mplier <= mplier >> digit;
               cnt    <= cnt + CW'(1);
               // r only moves when a new product is complete, so it holds
               // the previous result throughout a restart.
               if (last_step) r <= step_acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (width=16/digit=4 plus a 128-bit instance).
module tb_shift_add_multiplier;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int K  = W / D;
   localparam int WW = 128;
   localparam int WK = WW / D;

   logic            clk;
   logic            reset;
   logic            enable;
   logic [W-1:0]    a, b;
   logic            busy, done;
   logic [2*W-1:0]  r;

   logic            w_enable;
   logic [WW-1:0]   w_a, w_b;
   logic            w_busy, w_done;
   logic [2*WW-1:0] w_r;

   logic [2*W-1:0]  exp_q[$];
   int              errors;
   int              checks;

   shift_add_multiplier #(.width(W), .digit(D)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .r      (r)
   );

   shift_add_multiplier #(.width(WW), .digit(D)) dut_wide (
      .clk    (clk),
      .reset  (reset),
      .enable (w_enable),
      .a      (w_a),
      .b      (w_b),
      .busy   (w_busy),
      .done   (w_done),
      .r      (w_r)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a start request; returns at the negedge just after the capture edge.
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
      @(negedge clk);
      a      = ta;
      b      = tb_v;
      enable = 1'b1;
      exp_q.push_back(32'(ta) * 32'(tb_v));
      @(negedge clk);
      enable = 1'b0;
   endtask

   // Wait for done, counting edges since capture and busy-high samples.
   // With scramble set, enable/a/b are randomised every RUN cycle.
   task automatic wait_done(input bit scramble, output int edges, output int busy_cnt,
                            output bit timeout);
      edges    = 0;
      busy_cnt = 0;
      timeout  = 1'b0;
      while (!done && edges < 40) begin
         if (busy) busy_cnt++;
         if (scramble) begin
            enable = 1'($urandom_range(0, 1));
            a      = W'($urandom_range(0, 16'hFFFF));
            b      = W'($urandom_range(0, 16'hFFFF));
         end
         @(negedge clk);
         edges++;
      end
      enable = 1'b0;
      if (!done) timeout = 1'b1;
   endtask

   // scoreboard pop / compare
   task automatic check_result(input string name);
      logic [2*W-1:0] exp_v;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: result r=%0d with empty expected queue", name, r);
      end else begin
         exp_v = exp_q.pop_front();
         if (r !== exp_v) begin
            errors++;
            $display("FAIL %s: r=%0h expected %0h", name, r, exp_v);
         end
      end
   endtask

   task automatic run_and_check(input string name, input logic [W-1:0] ta,
                                input logic [W-1:0] tb_v);
      int e, bc;
      bit to;
      start_op(ta, tb_v);
      wait_done(1'b0, e, bc, to);
      checks++;
      if (to || e !== K) begin
         errors++;
         $display("FAIL %s latency: edges=%0d timeout=%0b expected %0d", name, e, to, K);
      end
      check_result(name);
   endtask

   task automatic test_reset;
      reset    = 1'b0;
      enable   = 1'b0;
      a        = '0;
      b        = '0;
      w_enable = 1'b0;
      w_a      = '0;
      w_b      = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, r} !== {1'b0, 1'b0, 32'd0}) begin
         errors++;
         $display("FAIL reset: busy=%0b done=%0b r=%0h expected 0 0 0", busy, done, r);
      end
      checks++;
      if ({w_busy, w_done, w_r} !== {2'b00, 256'd0}) begin
         errors++;
         $display("FAIL reset_wide: busy=%0b done=%0b r=%0h expected 0", w_busy, w_done, w_r);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: busy=%0b done=%0b expected 0 0", busy, done);
      end
   endtask

   task automatic test_basic;
      int e, bc;
      bit to;
      start_op(16'd37, 16'd12);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic busy_after_capture: busy=%0b expected 1", busy);
      end
      wait_done(1'b0, e, bc, to);
      checks++;
      if (to || e !== K) begin
         errors++;
         $display("FAIL basic latency: edges=%0d timeout=%0b expected %0d", e, to, K);
      end
      checks++;
      if (bc !== K) begin
         errors++;
         $display("FAIL basic busy_cycles: %0d expected %0d", bc, K);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic busy_in_done: busy=%0b expected 0", busy);
      end
      check_result("basic_37x12");
   endtask

   task automatic test_corners;
      run_and_check("max_x_max", 16'hFFFF, 16'hFFFF);
      run_and_check("zero_x_b", 16'h0000, 16'h1234);
      run_and_check("a_x_one", 16'hBEEF, 16'h0001);
   endtask

   task automatic test_done_hold_and_restart;
      int e, bc;
      bit to;
      run_and_check("pre_restart", 16'd37, 16'd12);
      repeat (5) @(negedge clk);
      checks++;
      if (done !== 1'b1 || r !== 32'd444) begin
         errors++;
         $display("FAIL done_hold: done=%0b r=%0d expected 1 444", done, r);
      end
      start_op(16'd100, 16'd23);
      checks++;
      if (done !== 1'b0 || r !== 32'd444) begin
         errors++;
         $display("FAIL restart_old_r: done=%0b r=%0d expected 0 444", done, r);
      end
      wait_done(1'b0, e, bc, to);
      checks++;
      if (to || e !== K) begin
         errors++;
         $display("FAIL restart latency: edges=%0d timeout=%0b expected %0d", e, to, K);
      end
      check_result("restart_100x23");
   endtask

   task automatic test_enable_ignored;
      int e, bc;
      bit to;
      start_op(16'd37, 16'd12);
      wait_done(1'b1, e, bc, to);
      checks++;
      if (to || e !== K) begin
         errors++;
         $display("FAIL scramble latency: edges=%0d timeout=%0b expected %0d", e, to, K);
      end
      check_result("scramble_37x12");
   endtask

   task automatic test_reset_mid_run;
      bit saw_done;
      start_op(16'd37, 16'd12);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, r} !== {1'b0, 1'b0, 32'd0}) begin
         errors++;
         $display("FAIL mid_reset: busy=%0b done=%0b r=%0h expected 0 0 0", busy, done, r);
      end
      exp_q.delete();
      @(negedge clk);
      reset    = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_quiet: activity=%0b expected 0", saw_done);
      end
      run_and_check("after_reset", 16'd7, 16'd9);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 8; i++) begin
         run_and_check("random", W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)));
      end
   endtask

   task automatic test_wide;
      int e;
      @(negedge clk);
      w_a      = 128'd100;
      w_b      = 128'd23;
      w_enable = 1'b1;
      @(negedge clk);
      w_enable = 1'b0;
      w_a      = '1;
      w_b      = '1;
      e        = 0;
      while (!w_done && e < 80) begin
         @(negedge clk);
         e++;
      end
      checks++;
      if (!w_done || e !== WK) begin
         errors++;
         $display("FAIL wide latency: edges=%0d done=%0b expected %0d", e, w_done, WK);
      end
      checks++;
      if (w_r !== 256'd2300) begin
         errors++;
         $display("FAIL wide product: r=%0d expected 2300", w_r);
      end
      checks++;
      if ((w_r % 256'd37) !== 256'd6) begin
         errors++;
         $display("FAIL wide mod37: r%%37=%0d expected 6", w_r % 256'd37);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_basic();
      test_corners();
      test_done_hold_and_restart();
      test_enable_ignored();
      test_reset_mid_run();
      test_back_to_back();
      test_wide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Iterative digit-serial integer multiplier. Produces the full 2*width-bit product r = a*b from two width-bit operands. It uses the same enable/done/r handshake style as the BarrettReduction block and acts as the producer side of that interface. Its r output feeds BarrettReduction's a input directly, so the two blocks together form the modular-multiply datapath of the MSM core.

Parameters:
width, 128, operand width in bits; product width is 2*width.
digit, 4, multiplier bits consumed per RUN cycle; width % digit must be 0, otherwise elaboration fails with $error.

Ports:
clk  input  1  rising-edge clock; the block's only clock.
reset  input  1  asynchronous, active-low reset; clears all state.
enable  input  1  start request; sampled only in IDLE or DONE.
a  input  width  multiplicand; captured on the start edge.
b  input  width  multiplier; captured on the start edge.
busy  output  1  high while in RUN.
done  output  1  high while in DONE; r is valid and stable.
r  output  2*width  product a*b.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release): state=IDLE, done=0, busy=0, r=0, all internal registers=0.
- K = width/digit. States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE, enable=1 at edge t0: latch a into mcand and b into mplier shift register, acc=0, cnt=0; next state RUN.
- IDLE, enable=0: remain in IDLE.
- RUN: each edge adds (mplier[digit-1:0] * mcand) << (cnt*digit) into acc, shifts mplier right by digit, increments cnt. The equivalent right-shifting-accumulator form is permitted; the result and cycle count must match.
- RUN exit: at edge t0+K, acc holds a*b; r<=acc, done<=1, busy<=0; next state DONE.
- Latency: done first high K edges after the capture edge (t0+K). busy is high from t0 until t0+K.
- enable during RUN is ignored; operands cannot be updated mid-operation.
- a and b may change freely after t0 without affecting the result.
- DONE, enable=0: hold r and done indefinitely.
- DONE, enable=1: identical to start from IDLE. New operands are captured, done drops at the next edge, r keeps its old value until the new result lands.
- Arithmetic: unsigned, exact, no truncation. acc is 2*width bits wide and per-step partial products are width+digit bits wide, so overflow cannot occur.
- cnt width is clog2(K)+1. cnt must not wrap inside RUN; the RUN exit is decoded from cnt==K-1 on the final step.
- Reset mid-RUN: immediate abort; outputs return to their reset values and no stale done pulse appears after release.

Decomposition:
- Shared package (mul_pkg): state typedef {IDLE, RUN, DONE}; localparam function for K; clog2 helper for cnt width.
- One natural combinational sub-module, mul_digit_step. Inputs: acc, mcand, digit slice, cnt. Output: next acc. This isolates the width×digit partial product for later retiming or DSP mapping.

Test Plan:
- width=16, digit=4, a=37, b=12 -> done at t0+4, r=444, busy high exactly 4 cycles.
- width=16, digit=4, a=16'hFFFF, b=16'hFFFF -> r=32'hFFFE0001; a=0, b=16'h1234 -> r=0.
- From DONE with r=444, enable=1 with a=100, b=23 -> done low at the next edge, r=2300 at +4 edges.
- During RUN, toggle enable and change a and b every cycle -> result unchanged: a=37, b=12 still gives r=444.
- reset=0 pulse at the 2nd RUN cycle -> done=0, busy=0, r=0 immediately; after release, no done until a new enable.
- Integration with width=128, digit=4: r(a=100, b=23) drives BarrettReduction with p=37 -> final result 6.
